// File: rtl/stopwatch_counter_pkg.sv
// Shared constants and types for the MM:SS stopwatch counter.
package stopwatch_counter_pkg;
  typedef logic [3:0] bcd_t;

  localparam bcd_t TENS_MAX = 4'd5;
  localparam bcd_t ONES_MAX = 4'd9;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } sw_state_e;
endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter, 00..59, advanced by one on each inc.
module bcd_mod60
  import stopwatch_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output bcd_t tens,
  output bcd_t ones,
  output logic carry
);
  logic ones_top, tens_top;

  // Treat any out-of-range digit as "at top" so the next increment returns it to 0.
  assign ones_top = (ones >= ONES_MAX);
  assign tens_top = (tens >= TENS_MAX);
  assign carry    = inc & ones_top & tens_top;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (ones_top) begin
        ones <= '0;
        tens <= tens_top ? '0 : tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
        if (tens > TENS_MAX) tens <= '0;
      end
    end
  end
endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch MM:SS counter: run/pause FSM, run vs adjust tick gating, seconds-to-minutes carry.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tick_1hz,
  input  logic tick_2hz,
  input  logic pause_p,
  input  logic adj,
  input  logic sel,
  output bcd_t min_tens,
  output bcd_t min_ones,
  output bcd_t sec_tens,
  output bcd_t sec_ones,
  output logic running,
  output logic wrap_p
);
  sw_state_e state, state_nx;
  logic run_tick, adj_tick;
  logic sec_inc, min_inc, sec_carry, min_carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (pause_p) state_nx = (state == ST_RUN) ? ST_PAUSED : ST_RUN;
  end

  // Gating uses the current state, so a tick coincident with pause follows the old state.
  always_comb begin
    run_tick = ~adj & tick_1hz & (state == ST_RUN);
    adj_tick = adj & tick_2hz;
    sec_inc  = run_tick | (adj_tick & sel);
    min_inc  = (run_tick & sec_carry) | (adj_tick & ~sel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b1;
      wrap_p  <= 1'b0;
    end else begin
      running <= (state_nx == ST_RUN);
      wrap_p  <= run_tick & min_carry;
    end
  end

  bcd_mod60 u_sec (
    .clk  (clk),
    .rst  (rst),
    .inc  (sec_inc),
    .tens (sec_tens),
    .ones (sec_ones),
    .carry(sec_carry)
  );

  bcd_mod60 u_min (
    .clk  (clk),
    .rst  (rst),
    .inc  (min_inc),
    .tens (min_tens),
    .ones (min_ones),
    .carry(min_carry)
  );
endmodule

// File: tb/tb_stopwatch_counter.sv
// Randomized + directed bench for stopwatch_counter against an integer minutes/seconds model.
module tb_stopwatch_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick_1hz = 1'b0, tick_2hz = 1'b0, pause_p = 1'b0, adj = 1'b0, sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic running, wrap_p;

  int n_chk = 0;
  int n_err = 0;

  // reference model
  int  m_min = 0, m_sec = 0;
  bit  m_run = 1'b1, m_wrap = 1'b0;

  stopwatch_counter dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .pause_p(pause_p), .adj(adj), .sel(sel),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .wrap_p(wrap_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_digits(input int mm, input int ss);
    exp_digits = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] dut_digits();
    dut_digits = {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".digits"}, dut_digits(), exp_digits(m_min, m_sec));
    chk({tag, ".running"}, running, m_run);
    chk({tag, ".wrap"}, wrap_p, m_wrap);
  endtask

  // One stimulus cycle followed by an idle cycle, keeping every strobe one clk wide.
  task automatic cyc(input bit t1, input bit t2, input bit p, input bit a, input bit s);
    @(negedge clk);
    tick_1hz = t1; tick_2hz = t2; pause_p = p; adj = a; sel = s;
    @(posedge clk);
    m_wrap = 1'b0;
    if (a) begin
      if (t2) begin
        if (s) m_sec = (m_sec + 1) % 60;
        else   m_min = (m_min + 1) % 60;
      end
    end else if (t1 && m_run) begin
      m_sec++;
      if (m_sec == 60) begin
        m_sec = 0;
        m_min++;
        if (m_min == 60) begin
          m_min  = 0;
          m_wrap = 1'b1;
        end
      end
    end
    if (p) m_run = !m_run;
    #1 check_all("cyc");
    @(negedge clk);
    tick_1hz = 1'b0; tick_2hz = 1'b0; pause_p = 1'b0;
  endtask

  // Reset raised between edges; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    tick_1hz = 1'b0; tick_2hz = 1'b0; pause_p = 1'b0;
    #2 rst = 1'b1;
    m_min = 0; m_sec = 0; m_run = 1'b1; m_wrap = 1'b0;
    #1 check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic preload(input int mm, input int ss);
    for (int i = 0; i < mm; i++) cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < ss; i++) cyc(0, 1, 0, 1, 1);
  endtask

  initial begin
    bit adj_lvl, sel_lvl;
    int r;

    // reset state, then 61 run ticks
    do_reset("rst0");
    for (int i = 0; i < 61; i++) cyc(1, 0, 0, 0, 0);
    chk("run61.digits", dut_digits(), 16'h0101);
    chk("run61.running", running, 1'b1);

    // 59:58 -> 59:59 -> 00:00 with single-cycle wrap
    do_reset("rst1");
    preload(59, 58);
    chk("pre.digits", dut_digits(), 16'h5958);
    cyc(1, 0, 0, 0, 0);
    chk("wrap.5959", dut_digits(), 16'h5959);
    chk("wrap.none", wrap_p, 1'b0);
    cyc(1, 0, 0, 0, 0);
    chk("wrap.0000", dut_digits(), 16'h0000);
    chk("wrap.high", wrap_p, 1'b1);
    @(posedge clk); #1;
    chk("wrap.drop", wrap_p, 1'b0);

    // pause ignores ticks; resume counts
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
    chk("pause.digits", dut_digits(), 16'h0000);
    chk("pause.running", running, 1'b0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("resume.digits", dut_digits(), 16'h0001);
    // tick_2hz ignored with adj=0, tick_1hz ignored with adj=1
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 1);
    chk("ignore.digits", dut_digits(), 16'h0001);

    // adjust seconds wraps without carry; adjust minutes wraps without wrap_p
    do_reset("rst2");
    preload(0, 58);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 1);
    chk("adjsec.digits", dut_digits(), 16'h0001);
    preload(59, 0);
    cyc(0, 1, 0, 1, 0);
    chk("adjmin.digits", dut_digits(), 16'h0001);
    chk("adjmin.wrap", wrap_p, 1'b0);
    // simultaneous ticks in adjust: one increment only
    cyc(1, 1, 0, 1, 1);
    chk("both.digits", dut_digits(), 16'h0002);

    // pause coincident with run tick at 00:10
    do_reset("rst3");
    preload(0, 10);
    cyc(1, 0, 1, 0, 0);
    chk("pt.digits", dut_digits(), 16'h0011);
    chk("pt.running", running, 1'b0);
    // in PAUSED the coincident tick is dropped and state returns to RUN
    cyc(1, 0, 1, 0, 0);
    chk("pt2.digits", dut_digits(), 16'h0011);
    chk("pt2.running", running, 1'b1);

    // async reset at 12:34, then first tick yields 00:01
    preload(12, 23);
    chk("pre1234", dut_digits(), 16'h1234);
    do_reset("arst");
    chk("arst.digits", dut_digits(), 16'h0000);
    cyc(1, 0, 0, 0, 0);
    chk("arst.first", dut_digits(), 16'h0001);

    // randomized traffic against the model
    adj_lvl = 1'b0; sel_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 299);
      if (r == 0) do_reset("rnd.rst");
      else begin
        if ($urandom_range(0, 19) == 0) adj_lvl = !adj_lvl;
        if ($urandom_range(0, 7) == 0)  sel_lvl = !sel_lvl;
        cyc($urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, adj_lvl, sel_lvl);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter: none; all limits fixed at 59:59 via shared package constants.
REQ-002 clk  input  1  system clock; all state updates on its rising edge; one clock domain only.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 tick_1hz  input  1  one-clk-wide pulse at 1 Hz, the run-mode count strobe.
REQ-005 tick_2hz  input  1  one-clk-wide pulse at 2 Hz, the adjust-mode count strobe.
REQ-006 pause_p  input  1  one-clk-wide debounced pause-button pulse.
REQ-007 adj  input  1  level; 1 = adjust mode.
REQ-008 sel  input  1  level; in adjust mode 0 = minutes field, 1 = seconds field.
REQ-009 min_tens  output  4  BCD minutes tens digit, 0..5, feeds the display stage.
REQ-010 min_ones  output  4  BCD minutes ones digit, 0..9.
REQ-011 sec_tens  output  4  BCD seconds tens digit, 0..5.
REQ-012 sec_ones  output  4  BCD seconds ones digit, 0..9.
REQ-013 running  output  1  1 when FSM is in RUN.
REQ-014 wrap_p  output  1  one-clk pulse when run-mode count rolls 59:59 -> 00:00.

Function
REQ-015 FSM shall have two states, RUN and PAUSED; pause_p toggles RUN<->PAUSED on the cycle it is sampled, in any adj/sel setting.
REQ-016 In RUN with adj=0, each tick_1hz shall advance seconds by one, registered on that same edge (digits change one cycle after tick is sampled high).
REQ-017 Seconds rollover 59 -> 00 shall carry +1 into minutes in the same cycle; minutes rollover 59 -> 00 with seconds rollover shall yield 00:00 and assert wrap_p for exactly that cycle.
REQ-018 In PAUSED with adj=0, tick_1hz shall be ignored and all digits held.
REQ-019 With adj=1, tick_1hz shall be ignored regardless of FSM state; each tick_2hz shall increment only the field chosen by sel, modulo 60, with no carry into the other field and no wrap_p.
REQ-020 With adj=0, tick_2hz shall be ignored.
REQ-021 sel or adj changes shall take effect on the next tick; no partial increment is stored.
REQ-022 Simultaneous tick_1hz and tick_2hz shall produce at most one increment, chosen by adj per REQ-016/REQ-019.
REQ-023 Simultaneous pause_p and tick_1hz in RUN: the tick shall be counted and the state shall become PAUSED; in PAUSED: the tick shall be ignored and the state shall become RUN.
REQ-024 Digit outputs shall be driven directly from registers, never exceeding 5/9/5/9; any illegal stored value shall be corrected to 0 on its next increment.
REQ-025 running and wrap_p shall be registered outputs.

Reset
REQ-026 rst high shall immediately force all digits to 0, state to RUN, running=1, wrap_p=0, regardless of clock.
REQ-027 rst asserted mid-count or mid-adjust shall abort with no increment; the first tick_1hz after deassertion (adj=0) shall yield 00:01.

Structure
REQ-028 Shared package shall hold TENS_MAX=5, ONES_MAX=9, state encodings ST_RUN/ST_PAUSED, and the 4-bit BCD digit type.
REQ-029 One sub-module, bcd_mod60 (inputs inc; outputs tens, ones, carry), shall be instantiated twice: seconds and minutes.
REQ-030 FSM, tick gating, and carry routing shall live in stopwatch_counter.

Verification
REQ-031 Reset, adj=0, 61 tick_1hz pulses -> digits 0/1/0/1 (01:01), running=1.
REQ-032 Preload to 59:58, two tick_1hz -> 59:59 then 00:00 with wrap_p high exactly one cycle.
REQ-033 pause_p, then 5 tick_1hz -> digits unchanged, running=0; second pause_p, one tick -> +1 s.
REQ-034 adj=1, sel=1 at 00:58, three tick_2hz -> 00:01, minutes unchanged, wrap_p never high; sel=0 at 59:xx, one tick_2hz -> 00:xx.
REQ-035 pause_p coincident with tick_1hz in RUN at 00:10 -> 00:11, running=0 next cycle.
REQ-036 rst pulsed asynchronously between clock edges at 12:34 -> outputs 00:00 before next edge, running=1.
